pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Issue controller for the fetch/decode/execute pipeline: gates PC advance and the IF_ID->ID_EX decode stage.
//  Tracks in-flight register writes in a 32-entry scoreboard and stalls on RAW hazards (rs/rt vs pending rd).
//  Holds issue on BR/BNE until the branch resolves, flushes on taken, and drains then parks on HLT.
//  Sits beside the decoder. It consumes the fetched instruction word and the writeback retire strobe.
// PARAMETERS
//  NREG      32  architectural registers (scoreboard width); index width is $clog2(NREG)=5
//  CNT_W     16  width of performance counters
// PORTS
//  clock        in   1      single clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      pulse: leave IDLE/HALT and begin issuing
//  instr        in   32     fetched word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11]
//  instr_valid  in   1      instr is valid this cycle
//  wb_valid     in   1      a register write retires this cycle
//  wb_rd        in   5      register retired by wb_valid
//  br_resolve   in   1      execute stage has resolved the outstanding BR/BNE
//  br_taken     in   1      qualified by br_resolve
//  pc_en        out  1      advance PC / fetch
//  issue        out  1      decode stage captures instr (IF_ID->ID_EX enable)
//  bubble       out  1      decode stage inserts NOP (opcode 6'b001110) instead of instr
//  flush        out  1      one-cycle pulse: discard fetched/decoded wrong-path work
//  halted       out  1      HLT drained, pipeline parked
//  stall_cnt    out  CNT_W  hazard-stall cycles (see CONFIGURATION)
//  flush_cnt    out  CNT_W  taken-branch flushes (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; scoreboard=0; all outputs 0; counters 0.
//  States: IDLE, RUN, BR_WAIT, FLUSH, DRAIN, HALT.
//   IDLE   : outputs 0. start -> RUN.
//   RUN    : hazard = instr_valid & ((rd_rs(op) & sb_eff[rs]) | (rd_rt(op) & sb_eff[rt])).
//            sb_eff = scoreboard & ~(wb_valid ? 1<<wb_rd : 0), so a writeback bypasses in the same cycle.
//            hazard: issue=0, bubble=1, pc_en=0, stall_cnt++.
//            else if instr_valid: issue=1, pc_en=1, and the op is handled as follows:
//              writes_rd(op): set scoreboard[rd] at the next edge.
//              BR/BNE -> BR_WAIT.  HLT -> DRAIN.  NOP/illegal (op>=0x0F) issue as NOP, writing nothing.
//            !instr_valid: pc_en=1, issue=0, bubble=1.
//   BR_WAIT: pc_en=0, issue=0, bubble=1 until br_resolve.
//            br_resolve & br_taken -> FLUSH (flush_cnt++).  br_resolve & !br_taken -> RUN.
//   FLUSH  : exactly 1 cycle, flush=1, bubble=1, pc_en=1 (fetch the target); then -> RUN.
//   DRAIN  : pc_en=0, bubble=1; wait until scoreboard==0 after this cycle's clear -> HALT.
//   HALT   : halted=1, all else 0. start -> RUN (scoreboard is already 0).
//  Op classes: writes_rd = ADD,SUB,LI,SHL,SHR,AND,OR,XOR,MOV,ADI,MUL.
//              rd_rs = all of those except LI, plus BNE.  rd_rt = ADD,SUB,AND,OR,XOR,MUL,BNE.
//  Scoreboard update per edge: sb <= (sb & ~clr) | set. If set and clr hit the same reg, set wins.
//  wb_valid for a non-pending reg: no effect (no error). r0 is an ordinary register.
//  Outputs are combinational from state+inputs except halted, which is registered.
//  Hazard decision is zero-latency: issue in the same cycle instr_valid is seen.
//  Counters saturate at all-ones; no wrap.
//  reset_n asserted mid-branch/drain: immediate return to IDLE, scoreboard cleared.
//  start while in RUN/BR_WAIT/DRAIN: ignored.
// CONFIGURATION
//  PIPE_SEQ_PERF_EN defined  : stall_cnt/flush_cnt are live as above.
//  PIPE_SEQ_PERF_EN undefined: counter registers are not built; stall_cnt=flush_cnt=0.
//                              All other behaviour is identical.
// STRUCTURE
//  Package pipe_pkg: opcode localparams (OP_ADD=6'h00 .. OP_NOP=6'h0E), state enum.
//  pipe_pkg also holds functions writes_rd/rd_rs/rd_rt(op).
//  The same opcode constants are shared with decoder.
//  Sub-module pipe_scoreboard: NREG-bit set/clear vector, with a pending(idx) read that includes the clear bypass.
// TESTING
//  1) reset, start; ADD r3<-r1,r2 then SUB r4<-r3,r1, no wb -> SUB stalls; stall_cnt increments each cycle.
//     wb_valid,wb_rd=3 -> SUB issues that same cycle.
//  2) LI r5 then ADD r6<-r5,r5 with wb_rd=5 on the ADD cycle -> no stall; issue=1.
//  3) BNE issued -> pc_en=0 for 3 cycles; br_resolve&br_taken -> flush=1 for exactly 1 cycle; flush_cnt=1.
//     Not-taken variant: no flush, RUN next cycle.
//  4) MUL r7 then HLT -> DRAIN with pc_en=0; wb_rd=7 -> halted=1 next edge.
//     start -> RUN, halted=0.
//  5) Same-cycle issue writing r9 and wb_valid,wb_rd=9 -> scoreboard[9]=1 afterwards (set wins).
//  6) reset_n low during BR_WAIT -> all outputs 0 immediately, state IDLE, scoreboard 0.
//     Rerun 1) with PIPE_SEQ_PERF_EN undefined -> counters stay 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Opcode map, FSM state encoding and operand-class helper functions,
//          shared between the issue controller and the decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_LI  = 6'h02;
  localparam logic [5:0] OP_SHL = 6'h03;
  localparam logic [5:0] OP_SHR = 6'h04;
  localparam logic [5:0] OP_AND = 6'h05;
  localparam logic [5:0] OP_OR  = 6'h06;
  localparam logic [5:0] OP_XOR = 6'h07;
  localparam logic [5:0] OP_MOV = 6'h08;
  localparam logic [5:0] OP_ADI = 6'h09;
  localparam logic [5:0] OP_MUL = 6'h0A;
  localparam logic [5:0] OP_BR  = 6'h0B;
  localparam logic [5:0] OP_BNE = 6'h0C;
  localparam logic [5:0] OP_HLT = 6'h0D;
  localparam logic [5:0] OP_NOP = 6'h0E;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_BR_WAIT = 3'd2,
    S_FLUSH   = 3'd3,
    S_DRAIN   = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  function automatic logic writes_rd(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LI, OP_SHL, OP_SHR, OP_AND,
      OP_OR, OP_XOR, OP_MOV, OP_ADI, OP_MUL: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic rd_rs(input logic [5:0] op);
    return (writes_rd(op) && (op != OP_LI)) || (op == OP_BNE);
  endfunction

  function automatic logic rd_rt(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_BNE: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BR) || (op == OP_BNE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_sequencer_if.sv
// ============================================================================
// Module : pipeline_sequencer_if
// Brief  : Fetch/writeback/branch handshake bundle between the pipeline
//          datapath (master) and the issue controller (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_sequencer_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
);

  logic                    start;
  logic [31:0]             instr;
  logic                    instr_valid;
  logic                    wb_valid;
  logic [$clog2(NREG)-1:0] wb_rd;
  logic                    br_resolve;
  logic                    br_taken;

  logic                    pc_en;
  logic                    issue;
  logic                    bubble;
  logic                    flush;
  logic                    halted;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output start, instr, instr_valid, wb_valid, wb_rd, br_resolve, br_taken,
    input  pc_en, issue, bubble, flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, instr, instr_valid, wb_valid, wb_rd, br_resolve, br_taken,
    output pc_en, issue, bubble, flush, halted, stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipe_scoreboard.sv
// ============================================================================
// Module : pipe_scoreboard
// Brief  : Pending-write vector, one bit per architectural register. Reads
//          see this cycle's writeback clear so a retiring value never stalls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_scoreboard #(
  parameter int NREG = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    set_en,
  input  logic [$clog2(NREG)-1:0] set_idx,
  input  logic                    clr_en,
  input  logic [$clog2(NREG)-1:0] clr_idx,
  input  logic [$clog2(NREG)-1:0] rd_idx_a,
  input  logic [$clog2(NREG)-1:0] rd_idx_b,
  output logic                    pend_a,
  output logic                    pend_b,
  output logic                    empty_nxt
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] sb_eff;

  // Set is OR-ed in after the clear, so an issue and a retire to the same
  // register in one cycle leave it pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    sb_eff = sb_q & ~clr_vec;
    sb_d   = sb_eff | set_vec;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sb_q <= '0;
    else          sb_q <= sb_d;
  end

  assign pend_a    = sb_eff[rd_idx_a];
  assign pend_b    = sb_eff[rd_idx_b];
  assign empty_nxt = (sb_eff == '0);

endmodule

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module : pipeline_sequencer
// Brief  : Issue controller: RAW-hazard stalls, branch hold/flush, HLT drain.
//          PIPE_SEQ_PERF_EN builds the saturating stall/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  pipeline_sequencer_if.slave  bus
);

  localparam int IDX_W = $clog2(NREG);

  state_e           state_q;
  state_e           state_d;
  logic             halted_q;

  logic [5:0]       op;
  logic [IDX_W-1:0] rs;
  logic [IDX_W-1:0] rt;
  logic [IDX_W-1:0] rd;
  logic             pend_rs;
  logic             pend_rt;
  logic             sb_empty_nxt;

  logic             pc_en;
  logic             issue;
  logic             bubble;
  logic             flush;
  logic             hazard;
  logic             flush_hit;
  logic             set_en;

  assign op = bus.instr[31:26];
  assign rs = bus.instr[21 +: IDX_W];
  assign rt = bus.instr[16 +: IDX_W];
  assign rd = bus.instr[11 +: IDX_W];

  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[10:0];

  pipe_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_en    (set_en),
    .set_idx   (rd),
    .clr_en    (bus.wb_valid),
    .clr_idx   (bus.wb_rd),
    .rd_idx_a  (rs),
    .rd_idx_b  (rt),
    .pend_a    (pend_rs),
    .pend_b    (pend_rt),
    .empty_nxt (sb_empty_nxt)
  );

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    issue     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    hazard    = 1'b0;
    flush_hit = 1'b0;
    set_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end

      S_RUN: begin
        hazard = bus.instr_valid &
                 ((rd_rs(op) & pend_rs) | (rd_rt(op) & pend_rt));
        if (hazard) begin
          bubble = 1'b1;
        end else if (bus.instr_valid) begin
          issue  = 1'b1;
          pc_en  = 1'b1;
          set_en = writes_rd(op);
          if (is_branch(op))      state_d = S_BR_WAIT;
          else if (op == OP_HLT)  state_d = S_DRAIN;
        end else begin
          pc_en  = 1'b1;
          bubble = 1'b1;
        end
      end

      S_BR_WAIT: begin
        bubble = 1'b1;
        if (bus.br_resolve) begin
          if (bus.br_taken) begin
            state_d   = S_FLUSH;
            flush_hit = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      // Fetch of the branch target overlaps the discard of wrong-path work.
      S_FLUSH: begin
        flush   = 1'b1;
        bubble  = 1'b1;
        pc_en   = 1'b1;
        state_d = S_RUN;
      end

      S_DRAIN: begin
        bubble = 1'b1;
        if (sb_empty_nxt) state_d = S_HALT;
      end

      S_HALT: begin
        if (bus.start) state_d = S_RUN;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  assign bus.pc_en  = pc_en;
  assign bus.issue  = issue;
  assign bus.bubble = bubble;
  assign bus.flush  = flush;
  assign bus.halted = halted_q;

`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturate rather than wrap so a long run never reports a tiny count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_hit && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = hazard ^ flush_hit;
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module : tb_pipeline_sequencer
// Brief  : Directed self-checking bench for pipeline_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;
  import pipe_pkg::*;

`ifdef PIPE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  pipeline_sequencer_if #(.NREG(32), .CNT_W(16)) bus ();

  pipeline_sequencer #(.NREG(32), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [15:0] ec(input logic [15:0] v);
    return PERF ? v : 16'h0000;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    bus.instr_valid = v;
    bus.instr       = ins;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    bus.wb_valid = v;
    bus.wb_rd    = r;
  endtask

  task automatic outs(input string tag, input logic pc, input logic is,
                      input logic bu, input logic fl);
    chk1({tag, ".pc_en"},  bus.pc_en,  pc);
    chk1({tag, ".issue"},  bus.issue,  is);
    chk1({tag, ".bubble"}, bus.bubble, bu);
    chk1({tag, ".flush"},  bus.flush,  fl);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.instr      = '0;
    bus.instr_valid= 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_rd      = '0;
    bus.br_resolve = 1'b0;
    bus.br_taken   = 1'b0;

    #1;
    outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("reset.halted", bus.halted, 1'b0);
    chkc("reset.stall_cnt", bus.stall_cnt, 16'd0);
    chkc("reset.flush_cnt", bus.flush_cnt, 16'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // 1) RAW stall on r3, released by a same-cycle writeback
    bus.start = 1'b1;
    drive(1'b1, mk(OP_ADD, 5'd1, 5'd2, 5'd3));
    #1 outs("idle_start", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    #1 outs("add_r3", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(OP_SUB, 5'd3, 5'd1, 5'd4));
    #1 outs("sub_stall0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chkc("stall_cnt1", bus.stall_cnt, ec(16'd1));
    chk1("sub_stall1.issue", bus.issue, 1'b0);
    tick();
    chkc("stall_cnt2", bus.stall_cnt, ec(16'd2));
    wb(1'b1, 5'd3);
    #1 outs("sub_wb_bypass", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    wb(1'b0, 5'd0);
    chkc("stall_cnt_hold", bus.stall_cnt, ec(16'd2));

    // 2) LI r5 then ADD r6<-r5,r5 with r5 retiring in the same cycle
    drive(1'b1, mk(OP_LI, 5'd0, 5'd0, 5'd5));
    #1 chk1("li_r5.issue", bus.issue, 1'b1);
    tick();
    drive(1'b1, mk(OP_ADD, 5'd5, 5'd5, 5'd6));
    wb(1'b1, 5'd5);
    #1 outs("add_r5_bypass", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    wb(1'b0, 5'd0);

    // 3) taken BNE: hold, single-cycle flush
    drive(1'b1, mk(OP_BNE, 5'd1, 5'd2, 5'd0));
    #1 chk1("bne.issue", bus.issue, 1'b1);
    tick();
    drive(1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 outs("br_wait", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    bus.br_resolve = 1'b1;
    bus.br_taken   = 1'b1;
    #1 outs("br_resolve_taken", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.br_resolve = 1'b0;
    bus.br_taken   = 1'b0;
    #1 outs("flush_cycle", 1'b1, 1'b0, 1'b1, 1'b1);
    chkc("flush_cnt1", bus.flush_cnt, ec(16'd1));
    tick();
    outs("after_flush", 1'b1, 1'b0, 1'b1, 1'b0);

    // not-taken BR: straight back to RUN
    drive(1'b1, mk(OP_BR, 5'd0, 5'd0, 5'd0));
    #1 chk1("br.issue", bus.issue, 1'b1);
    tick();
    drive(1'b0, 32'd0);
    bus.br_resolve = 1'b1;
    #1 outs("br_resolve_nt", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.br_resolve = 1'b0;
    drive(1'b1, mk(OP_NOP, 5'd0, 5'd0, 5'd0));
    #1 outs("nt_run", 1'b1, 1'b1, 1'b0, 1'b0);
    chkc("flush_cnt_nt", bus.flush_cnt, ec(16'd1));
    tick();
    drive(1'b0, 32'd0);
    wb(1'b1, 5'd4);
    tick();
    wb(1'b1, 5'd6);
    tick();
    wb(1'b0, 5'd0);

    // 4) MUL r7 then HLT: drain until r7 retires, then park
    drive(1'b1, mk(OP_MUL, 5'd1, 5'd2, 5'd7));
    tick();
    drive(1'b1, mk(OP_HLT, 5'd0, 5'd0, 5'd0));
    #1 chk1("hlt.issue", bus.issue, 1'b1);
    tick();
    drive(1'b0, 32'd0);
    bus.start = 1'b1;
    #1 outs("drain", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.start = 1'b0;
    chk1("drain.halted", bus.halted, 1'b0);
    wb(1'b1, 5'd7);
    #1 chk1("drain_wb.halted", bus.halted, 1'b0);
    tick();
    wb(1'b0, 5'd0);
    chk1("halt.halted", bus.halted, 1'b1);
    outs("halt", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1 chk1("restart.halted", bus.halted, 1'b0);
    chk1("restart.pc_en", bus.pc_en, 1'b1);

    // 5) set wins over a same-cycle clear of r9
    drive(1'b1, mk(OP_ADD, 5'd1, 5'd2, 5'd9));
    wb(1'b1, 5'd9);
    tick();
    wb(1'b0, 5'd0);
    drive(1'b1, mk(OP_SUB, 5'd9, 5'd1, 5'd11));
    #1 chk1("r9_pending.issue", bus.issue, 1'b0);
    tick();
    chkc("stall_cnt3", bus.stall_cnt, ec(16'd3));
    wb(1'b1, 5'd9);
    #1 chk1("r9_retire.issue", bus.issue, 1'b1);
    tick();
    wb(1'b0, 5'd0);

    // illegal opcode issues but reserves nothing
    drive(1'b1, mk(6'h3F, 5'd0, 5'd0, 5'd12));
    #1 chk1("illegal.issue", bus.issue, 1'b1);
    tick();
    drive(1'b1, mk(OP_ADD, 5'd12, 5'd12, 5'd13));
    #1 chk1("after_illegal.issue", bus.issue, 1'b1);
    tick();

    // 6) async reset while waiting on a branch (r11, r13 still pending)
    drive(1'b1, mk(OP_BR, 5'd0, 5'd0, 5'd0));
    tick();
    drive(1'b0, 32'd0);
    #1 chk1("br_wait_pre_rst.bubble", bus.bubble, 1'b1);
    #1 reset_n = 1'b0;
    #1 outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("mid_reset.halted", bus.halted, 1'b0);
    chkc("mid_reset.stall_cnt", bus.stall_cnt, 16'd0);
    chkc("mid_reset.flush_cnt", bus.flush_cnt, 16'd0);
    tick();
    reset_n = 1'b1;
    bus.start = 1'b1;
    drive(1'b1, mk(OP_ADD, 5'd11, 5'd13, 5'd2));
    #1 chk1("post_rst_idle.issue", bus.issue, 1'b0);
    tick();
    bus.start = 1'b0;
    #1 chk1("sb_cleared.issue", bus.issue, 1'b1);
    tick();

    // stall counter saturation on a long-held hazard on r2
    drive(1'b1, mk(OP_SUB, 5'd2, 5'd2, 5'd3));
    repeat (65540) @(posedge clock);
    #1;
    chk1("sat.issue", bus.issue, 1'b0);
    chkc("sat.stall_cnt", bus.stall_cnt, ec(16'hFFFF));
    wb(1'b1, 5'd2);
    #1 chk1("sat_release.issue", bus.issue, 1'b1);
    tick();
    wb(1'b0, 5'd0);
    drive(1'b0, 32'd0);
    chkc("sat_hold.stall_cnt", bus.stall_cnt, ec(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
